// File: rtl/gt_reset_seq.sv
// gt_reset_seq: PLL -> GT -> PCS reset sequencer for the 10G GTX PHY.
// Lock and reset-done status are re-timed through sync_block before use.

module sync_block #(
   parameter int STAGES = 6
) (
   input  logic clk,
   input  logic i_d,
   output logic o_q
);
   // Power-up value matches INITIALISE of the vendor primitive; no reset.
   logic [STAGES-1:0] r_sync = '0;

   always_ff @(posedge clk) begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];
endmodule

module gt_reset_seq #(
   parameter int RST_HOLD     = 16,
   parameter int PLL_TIMEOUT  = 50000,
   parameter int DONE_TIMEOUT = 50000,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_lock_async,
   input  logic       gt_resetdone_async,
   output logic       pll_reset,
   output logic       gt_reset,
   output logic       pcs_reset,
   output logic       phy_ready,
   output logic [3:0] retry_cnt,
   output logic [2:0] state
);
   typedef enum logic [2:0] {
      S_RESET     = 3'd0,
      S_PLL_WAIT  = 3'd1,
      S_GT_RST    = 3'd2,
      S_DONE_WAIT = 3'd3,
      S_PCS_RST   = 3'd4,
      S_READY     = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_retry;
   logic             r_pll_reset;
   logic             r_gt_reset;
   logic             r_pcs_reset;
   logic             r_phy_ready;

   logic w_lock_s;
   logic w_done_s;
   logic w_retry;
   logic w_hold_end;
   logic w_pll_to;
   logic w_done_to;
   logic w_pll_rst;
   logic w_gt_rst;
   logic w_pcs_rst;
   logic w_rdy;

   sync_block #(.STAGES(6)) u_sync_lock (
      .clk (clk),
      .i_d (pll_lock_async),
      .o_q (w_lock_s)
   );

   sync_block #(.STAGES(6)) u_sync_done (
      .clk (clk),
      .i_d (gt_resetdone_async),
      .o_q (w_done_s)
   );

   assign w_hold_end = (r_cnt == HOLD_LAST);
   assign w_pll_to   = (r_cnt == PLL_LAST);
   assign w_done_to  = (r_cnt == DONE_LAST);

   always_comb begin
      w_next  = r_state;
      w_retry = 1'b0;
      unique case (r_state)
         S_RESET: begin
            if (w_hold_end) w_next = S_PLL_WAIT;
         end
         S_PLL_WAIT: begin
            if (w_lock_s) begin
               w_next = S_GT_RST;
            end else if (w_pll_to) begin
               w_next  = S_RESET;
               w_retry = 1'b1;
            end
         end
         S_GT_RST: begin
            if (!w_lock_s)       w_next = S_RESET;
            else if (w_hold_end) w_next = S_DONE_WAIT;
         end
         S_DONE_WAIT: begin
            if (!w_lock_s) begin
               w_next = S_RESET;
            end else if (w_done_s) begin
               w_next = S_PCS_RST;
            end else if (w_done_to) begin
               w_next  = S_GT_RST;
               w_retry = 1'b1;
            end
         end
         S_PCS_RST: begin
            if (!w_lock_s)       w_next = S_RESET;
            else if (!w_done_s)  w_next = S_GT_RST;
            else if (w_hold_end) w_next = S_READY;
         end
         S_READY: begin
            if (!w_lock_s)      w_next = S_RESET;
            else if (!w_done_s) w_next = S_GT_RST;
         end
         default: w_next = S_RESET;
      endcase
      if (rst) begin
         w_next  = S_RESET;
         w_retry = 1'b0;
      end
      // Outputs decode the next state so they register alongside it.
      w_pll_rst = (w_next == S_RESET);
      w_gt_rst  = (w_next == S_RESET) || (w_next == S_PLL_WAIT) ||
                  (w_next == S_GT_RST);
      w_pcs_rst = (w_next != S_READY);
      w_rdy     = (w_next == S_READY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_RESET;
         r_cnt   <= '0;
         r_retry <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
         if (w_retry && (r_retry != 4'hF)) r_retry <= r_retry + 1'b1;
      end
      r_pll_reset <= w_pll_rst;
      r_gt_reset  <= w_gt_rst;
      r_pcs_reset <= w_pcs_rst;
      r_phy_ready <= w_rdy;
   end

   assign pll_reset = r_pll_reset;
   assign gt_reset  = r_gt_reset;
   assign pcs_reset = r_pcs_reset;
   assign phy_ready = r_phy_ready;
   assign retry_cnt = r_retry;
   assign state     = r_state;
endmodule

// File: tb/tb_gt_reset_seq.sv
// Scoreboard bench for gt_reset_seq: stimulus queues expected snapshots
// keyed by cycle; a monitor pops and compares them when the cycle arrives.

module tb_gt_reset_seq;
   logic       clk;
   logic       rst;
   logic       lock;
   logic       done;
   logic       pll_reset;
   logic       gt_reset;
   logic       pcs_reset;
   logic       phy_ready;
   logic [3:0] retry_cnt;
   logic [2:0] state;

   typedef struct {
      int         c;
      string      nm;
      logic [2:0] st;
      logic [3:0] o;
      logic [3:0] rt;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int   cyc;
   int   checks;
   int   errors;
   int   rdy_seen;
   bit   in_pll_to;

   // {pll_reset, gt_reset, pcs_reset, phy_ready}
   localparam logic [3:0] O_RST  = 4'b1110;
   localparam logic [3:0] O_PLLW = 4'b0110;
   localparam logic [3:0] O_GT   = 4'b0110;
   localparam logic [3:0] O_DW   = 4'b0010;
   localparam logic [3:0] O_PCS  = 4'b0010;
   localparam logic [3:0] O_RDY  = 4'b0001;

   gt_reset_seq #(
      .RST_HOLD     (4),
      .PLL_TIMEOUT  (32),
      .DONE_TIMEOUT (32),
      .CNT_W        (16)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .pll_lock_async     (lock),
      .gt_resetdone_async (done),
      .pll_reset          (pll_reset),
      .gt_reset           (gt_reset),
      .pcs_reset          (pcs_reset),
      .phy_ready          (phy_ready),
      .retry_cnt          (retry_cnt),
      .state              (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_at(input int c, input string nm,
                            input logic [2:0] st, input logic [3:0] o,
                            input logic [3:0] rt);
      exp_t e;
      e.c  = c;
      e.nm = nm;
      e.st = st;
      e.o  = o;
      e.rt = rt;
      q.push_back(e);
   endtask

   task automatic go(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   always @(posedge clk) begin
      #1;
      if (in_pll_to && phy_ready) rdy_seen = rdy_seen + 1;
      while (q.size() > 0 && q[0].c <= cyc) begin
         m_e = q.pop_front();
         checks = checks + 1;
         if (m_e.c != cyc || state !== m_e.st ||
             {pll_reset, gt_reset, pcs_reset, phy_ready} !== m_e.o ||
             retry_cnt !== m_e.rt) begin
            errors = errors + 1;
            $display("FAIL %s cyc=%0d got st=%0d o=%b rt=%0d exp c=%0d st=%0d o=%b rt=%0d",
                     m_e.nm, cyc, state,
                     {pll_reset, gt_reset, pcs_reset, phy_ready},
                     retry_cnt, m_e.c, m_e.st, m_e.o, m_e.rt);
         end
      end
   end

   initial begin
      int c0;
      int t;
      int d;
      checks    = 0;
      errors    = 0;
      rdy_seen  = 0;
      in_pll_to = 1'b0;
      rst  = 1'b1;
      lock = 1'b1;
      done = 1'b1;
      expect_at(3, "rst_state", 3'd0, O_RST, 4'd0);
      repeat (10) @(negedge clk);

      // nominal bring-up
      c0  = cyc;
      rst = 1'b0;
      expect_at(c0 + 3,  "nom_rst_end", 3'd0, O_RST,  4'd0);
      expect_at(c0 + 4,  "nom_pllwait", 3'd1, O_PLLW, 4'd0);
      expect_at(c0 + 5,  "nom_gt",      3'd2, O_GT,   4'd0);
      expect_at(c0 + 8,  "nom_gt_end",  3'd2, O_GT,   4'd0);
      expect_at(c0 + 9,  "nom_dw",      3'd3, O_DW,   4'd0);
      expect_at(c0 + 10, "nom_pcs",     3'd4, O_PCS,  4'd0);
      expect_at(c0 + 13, "nom_pcs_end", 3'd4, O_PCS,  4'd0);
      expect_at(c0 + 14, "nom_ready",   3'd5, O_RDY,  4'd0);
      go(c0 + 20);

      // lock loss in READY
      t    = cyc;
      lock = 1'b0;
      expect_at(t + 6, "ll_still_rdy", 3'd5, O_RDY, 4'd0);
      expect_at(t + 7, "ll_reset",     3'd0, O_RST, 4'd0);
      go(t + 10);
      lock = 1'b1;
      expect_at(t + 11, "ll_pllwait", 3'd1, O_PLLW, 4'd0);
      expect_at(t + 17, "ll_gt",      3'd2, O_GT,   4'd0);
      expect_at(t + 26, "ll_ready",   3'd5, O_RDY,  4'd0);
      go(t + 30);

      // done loss in READY
      t    = cyc;
      done = 1'b0;
      expect_at(t + 6, "dl_still_rdy", 3'd5, O_RDY, 4'd0);
      expect_at(t + 7, "dl_gt",        3'd2, O_GT,  4'd0);
      go(t + 8);
      done = 1'b1;
      expect_at(t + 11, "dl_dw",    3'd3, O_DW,  4'd0);
      expect_at(t + 15, "dl_pcs",   3'd4, O_PCS, 4'd0);
      expect_at(t + 19, "dl_ready", 3'd5, O_RDY, 4'd0);
      go(t + 25);

      // reset-done timeout loop
      done = 1'b0;
      rst  = 1'b1;
      repeat (8) @(negedge clk);
      c0  = cyc;
      rst = 1'b0;
      expect_at(c0 + 3,   "dt_rst",   3'd0, O_RST, 4'd0);
      expect_at(c0 + 9,   "dt_dw0",   3'd3, O_DW,  4'd0);
      expect_at(c0 + 40,  "dt_dw0_e", 3'd3, O_DW,  4'd0);
      expect_at(c0 + 41,  "dt_gt1",   3'd2, O_GT,  4'd1);
      expect_at(c0 + 45,  "dt_dw1",   3'd3, O_DW,  4'd1);
      expect_at(c0 + 77,  "dt_gt2",   3'd2, O_GT,  4'd2);
      expect_at(c0 + 113, "dt_gt3",   3'd2, O_GT,  4'd3);
      expect_at(c0 + 120, "dt_dw3",   3'd3, O_DW,  4'd3);
      go(c0 + 120);

      // rst pulse mid DONE_WAIT
      rst = 1'b1;
      expect_at(c0 + 121, "mr_reset", 3'd0, O_RST, 4'd0);
      @(negedge clk);
      rst = 1'b0;
      expect_at(c0 + 124, "mr_rst_end", 3'd0, O_RST,  4'd0);
      expect_at(c0 + 125, "mr_pllwait", 3'd1, O_PLLW, 4'd0);
      d = c0 + 130;
      expect_at(d, "mr_dw", 3'd3, O_DW, 4'd0);
      go(d + 10);
      done = 1'b1;
      expect_at(d + 16, "dr_dw",    3'd3, O_DW,  4'd0);
      expect_at(d + 17, "dr_pcs",   3'd4, O_PCS, 4'd0);
      expect_at(d + 21, "dr_ready", 3'd5, O_RDY, 4'd0);
      go(d + 25);

      // PLL never locks
      lock = 1'b0;
      rst  = 1'b1;
      repeat (8) @(negedge clk);
      c0        = cyc;
      rst       = 1'b0;
      in_pll_to = 1'b1;
      expect_at(c0 + 35,  "pt_pw_end", 3'd1, O_PLLW, 4'd0);
      expect_at(c0 + 36,  "pt_r1",     3'd0, O_RST,  4'd1);
      expect_at(c0 + 40,  "pt_pw1",    3'd1, O_PLLW, 4'd1);
      expect_at(c0 + 72,  "pt_r2",     3'd0, O_RST,  4'd2);
      expect_at(c0 + 540, "pt_r15",    3'd0, O_RST,  4'd15);
      expect_at(c0 + 576, "pt_sat",    3'd0, O_RST,  4'd15);
      expect_at(c0 + 611, "pt_sat_pw", 3'd1, O_PLLW, 4'd15);
      go(c0 + 615);
      in_pll_to = 1'b0;

      checks = checks + 1;
      if (rdy_seen != 0) begin
         errors = errors + 1;
         $display("FAIL pt_no_ready got %0d ready cycles, want 0", rdy_seen);
      end
      while (q.size() > 0) begin
         m_e    = q.pop_front();
         errors = errors + 1;
         $display("FAIL %s never compared (c=%0d)", m_e.nm, m_e.c);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
